// File: rtl/parking_gate_ctrl_if.sv
// Gate-side bundle for the parking gate controller: driver requests, pass
// sensors, vacancy flags and hour in; barrier drives and occupancy events out.
interface parking_gate_ctrl_if;
    logic [4:0] hour;
    logic       entry_req;
    logic       entry_is_uni;
    logic       entry_pass;
    logic       exit_req;
    logic       exit_is_uni;
    logic       exit_pass;
    logic       uni_is_vacated_space;
    logic       is_vacated_space;
    logic       car_entered;
    logic       is_uni_car_entered;
    logic       car_exited;
    logic       is_uni_car_exited;
    logic       entry_gate_open;
    logic       exit_gate_open;
    logic       entry_denied;
    logic [1:0] gate_timeout;

    // gate hardware / parking counter side
    modport master (
        output hour, entry_req, entry_is_uni, entry_pass,
               exit_req, exit_is_uni, exit_pass,
               uni_is_vacated_space, is_vacated_space,
        input  car_entered, is_uni_car_entered, car_exited, is_uni_car_exited,
               entry_gate_open, exit_gate_open, entry_denied, gate_timeout
    );

    // controller side
    modport slave (
        input  hour, entry_req, entry_is_uni, entry_pass,
               exit_req, exit_is_uni, exit_pass,
               uni_is_vacated_space, is_vacated_space,
        output car_entered, is_uni_car_entered, car_exited, is_uni_car_exited,
               entry_gate_open, exit_gate_open, entry_denied, gate_timeout
    );
endinterface

// File: rtl/parking_gate_ctrl.sv
// Parking gate controller: two independent barrier FSMs (entry, exit) that
// open on request, wait for the pass sensor with a bounded timeout and emit a
// one-cycle occupancy event to the parking counter. Entry additionally checks
// opening hours and class-specific vacancy before opening. All outputs are
// registered.
module parking_gate_ctrl #(
    parameter int OPEN_TIMEOUT = 16,
    parameter int HOLD_CYCLES  = 2,
    parameter int OPEN_HOUR    = 8,
    parameter int CLOSE_HOUR   = 24
) (
    input  logic                 clk,
    input  logic                 rst_n,
    parking_gate_ctrl_if.slave   bus
);
    localparam int TW = $clog2(OPEN_TIMEOUT) + 1;
    localparam int HW = $clog2(HOLD_CYCLES + 1) + 1;
    localparam logic [TW-1:0] TMO_LAST  = TW'(OPEN_TIMEOUT - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

    typedef enum logic [2:0] {E_IDLE, E_CHECK, E_OPEN, E_EMIT, E_HOLD} e_state_t;
    typedef enum logic [1:0] {X_IDLE, X_OPEN, X_EMIT, X_HOLD} x_state_t;

    e_state_t      e_state;
    x_state_t      x_state;
    logic [TW-1:0] e_tmr, x_tmr;
    logic [HW-1:0] e_hold, x_hold;
    logic          e_uni_q, x_uni_q;
    logic          e_to, x_to;
    logic          hour_ok, vac_ok;

    // Hours past 23 are invalid encodings and count as closed.
    assign hour_ok = (int'(bus.hour) >= OPEN_HOUR) && (int'(bus.hour) < CLOSE_HOUR)
                     && (bus.hour < 5'd24);
    // Vacancy of the class latched with the request.
    assign vac_ok  = e_uni_q ? bus.uni_is_vacated_space : bus.is_vacated_space;

    assign bus.gate_timeout = {x_to, e_to};

    // Entry FSM: request -> hour/vacancy check -> open -> event -> cooldown.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_state                <= E_IDLE;
            e_tmr                  <= '0;
            e_hold                 <= '0;
            e_uni_q                <= 1'b0;
            e_to                   <= 1'b0;
            bus.car_entered        <= 1'b0;
            bus.is_uni_car_entered <= 1'b0;
            bus.entry_gate_open    <= 1'b0;
            bus.entry_denied       <= 1'b0;
        end else begin
            bus.car_entered        <= 1'b0;
            bus.is_uni_car_entered <= 1'b0;
            bus.entry_denied       <= 1'b0;
            e_to                   <= 1'b0;
            case (e_state)
                E_IDLE: begin
                    if (bus.entry_req) begin
                        e_uni_q <= bus.entry_is_uni;
                        e_state <= E_CHECK;
                    end
                end
                E_CHECK: begin
                    if (hour_ok && vac_ok) begin
                        e_tmr               <= '0;
                        bus.entry_gate_open <= 1'b1;
                        e_state             <= E_OPEN;
                    end else begin
                        bus.entry_denied <= 1'b1;
                        e_state          <= E_IDLE;
                    end
                end
                E_OPEN: begin
                    // A pass in the timeout cycle still counts as a car.
                    if (bus.entry_pass) begin
                        bus.entry_gate_open    <= 1'b0;
                        bus.car_entered        <= 1'b1;
                        bus.is_uni_car_entered <= e_uni_q;
                        e_state                <= E_EMIT;
                    end else if (e_tmr == TMO_LAST) begin
                        bus.entry_gate_open <= 1'b0;
                        e_to                <= 1'b1;
                        e_state             <= E_IDLE;
                    end else if (e_tmr != '1) begin
                        e_tmr <= e_tmr + 1'b1;
                    end
                end
                E_EMIT: begin
                    e_hold  <= '0;
                    e_state <= (HOLD_CYCLES == 0) ? E_IDLE : E_HOLD;
                end
                E_HOLD: begin
                    if (e_hold == HOLD_LAST) e_state <= E_IDLE;
                    else                     e_hold  <= e_hold + 1'b1;
                end
                default: begin
                    bus.entry_gate_open <= 1'b0;
                    e_state             <= E_IDLE;
                end
            endcase
        end
    end

    // Exit FSM: same as entry but opens straight away, exit is never refused.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_state               <= X_IDLE;
            x_tmr                 <= '0;
            x_hold                <= '0;
            x_uni_q               <= 1'b0;
            x_to                  <= 1'b0;
            bus.car_exited        <= 1'b0;
            bus.is_uni_car_exited <= 1'b0;
            bus.exit_gate_open    <= 1'b0;
        end else begin
            bus.car_exited        <= 1'b0;
            bus.is_uni_car_exited <= 1'b0;
            x_to                  <= 1'b0;
            case (x_state)
                X_IDLE: begin
                    if (bus.exit_req) begin
                        x_uni_q            <= bus.exit_is_uni;
                        x_tmr              <= '0;
                        bus.exit_gate_open <= 1'b1;
                        x_state            <= X_OPEN;
                    end
                end
                X_OPEN: begin
                    if (bus.exit_pass) begin
                        bus.exit_gate_open    <= 1'b0;
                        bus.car_exited        <= 1'b1;
                        bus.is_uni_car_exited <= x_uni_q;
                        x_state               <= X_EMIT;
                    end else if (x_tmr == TMO_LAST) begin
                        bus.exit_gate_open <= 1'b0;
                        x_to               <= 1'b1;
                        x_state            <= X_IDLE;
                    end else if (x_tmr != '1) begin
                        x_tmr <= x_tmr + 1'b1;
                    end
                end
                X_EMIT: begin
                    x_hold  <= '0;
                    x_state <= (HOLD_CYCLES == 0) ? X_IDLE : X_HOLD;
                end
                X_HOLD: begin
                    if (x_hold == HOLD_LAST) x_state <= X_IDLE;
                    else                     x_hold  <= x_hold + 1'b1;
                end
                default: begin
                    bus.exit_gate_open <= 1'b0;
                    x_state            <= X_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Directed bench for parking_gate_ctrl with hand-computed expectations.
module tb_parking_gate_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;

    parking_gate_ctrl_if bus();

    parking_gate_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] outs();
        return {bus.car_entered, bus.is_uni_car_entered, bus.car_exited,
                bus.is_uni_car_exited, bus.entry_gate_open, bus.exit_gate_open,
                bus.entry_denied, bus.gate_timeout};
    endfunction

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    logic [4:0] den_hours [3];

    initial begin
        den_hours = '{5'd6, 5'd7, 5'd24};
        bus.hour = 5'd0;
        bus.entry_req = 0; bus.entry_is_uni = 0; bus.entry_pass = 0;
        bus.exit_req = 0;  bus.exit_is_uni = 0;  bus.exit_pass = 0;
        bus.uni_is_vacated_space = 0; bus.is_vacated_space = 0;

        // reset
        #2 rst_n = 1'b0;
        #1 chk("rst_outs", 32'(outs()), 0);
        step(2);
        rst_n = 1'b1;
        step(1);
        chk("post_rst_outs", 32'(outs()), 0);

        // 1: uni entry with pass three cycles after open
        bus.hour = 5'd9; bus.uni_is_vacated_space = 1; bus.is_vacated_space = 0;
        bus.entry_is_uni = 1; bus.entry_req = 1;
        step;
        bus.entry_req = 0; bus.entry_is_uni = 0;
        chk("t1_not_open_yet", 32'(bus.entry_gate_open), 0);
        step;
        chk("t1_open_at_2", 32'(bus.entry_gate_open), 1);
        step(2);
        chk("t1_still_open", 32'(bus.entry_gate_open), 1);
        chk("t1_no_early_event", 32'(bus.car_entered), 0);
        bus.entry_pass = 1;
        step;
        chk("t1_car_entered", 32'(bus.car_entered), 1);
        chk("t1_uni_entered", 32'(bus.is_uni_car_entered), 1);
        chk("t1_gate_closed", 32'(bus.entry_gate_open), 0);
        bus.entry_pass = 0;
        bus.entry_req = 1;              // arrives during cooldown, must be dropped
        step;
        bus.entry_req = 0;
        chk("t1_event_one_cycle", 32'(bus.car_entered), 0);
        chk("t1_uni_cleared", 32'(bus.is_uni_car_entered), 0);
        step(4);
        chk("t1_req_in_hold_ignored", 32'(outs()), 0);

        // 2: non-uni car, no non-uni space
        bus.hour = 5'd9; bus.uni_is_vacated_space = 1; bus.is_vacated_space = 0;
        bus.entry_is_uni = 0; bus.entry_req = 1;
        step;
        bus.entry_req = 0;
        step;
        chk("t2_denied", 32'(bus.entry_denied), 1);
        chk("t2_gate_shut", 32'(bus.entry_gate_open), 0);
        step;
        chk("t2_denied_one_cycle", 32'(bus.entry_denied), 0);
        chk("t2_gate_never", 32'(bus.entry_gate_open), 0);
        step(2);

        // 3: closed hours, then the opening-hour boundary and an entry timeout
        bus.uni_is_vacated_space = 1; bus.is_vacated_space = 1;
        for (int i = 0; i < 3; i++) begin
            bus.hour = den_hours[i];
            bus.entry_req = 1;
            step;
            bus.entry_req = 0;
            step;
            chk($sformatf("t3_denied_h%0d", den_hours[i]), 32'(bus.entry_denied), 1);
            chk($sformatf("t3_shut_h%0d", den_hours[i]), 32'(bus.entry_gate_open), 0);
            step;
        end
        bus.hour = 5'd8;
        bus.entry_req = 1;
        step;
        bus.entry_req = 0;
        step;
        chk("t3_open_h8", 32'(bus.entry_gate_open), 1);
        chk("t3_not_denied_h8", 32'(bus.entry_denied), 0);
        for (int i = 0; i < 15; i++) begin
            step;
            chk("t3_held_open", 32'(bus.entry_gate_open), 1);
        end
        step;
        chk("t3_entry_timeout", 32'(bus.gate_timeout), 2'b01);
        chk("t3_closed_on_timeout", 32'(bus.entry_gate_open), 0);
        chk("t3_no_event", 32'(bus.car_entered), 0);
        step;
        chk("t3_timeout_one_cycle", 32'(bus.gate_timeout), 0);
        step(2);

        // 4: exit with no pass
        bus.exit_is_uni = 1; bus.exit_req = 1;
        step;
        bus.exit_req = 0; bus.exit_is_uni = 0;
        chk("t4_exit_open_at_1", 32'(bus.exit_gate_open), 1);
        for (int i = 0; i < 15; i++) begin
            step;
            chk("t4_held_open", 32'(bus.exit_gate_open), 1);
        end
        step;
        chk("t4_exit_timeout", 32'(bus.gate_timeout), 2'b10);
        chk("t4_no_exit_event", 32'(bus.car_exited), 0);
        chk("t4_closed", 32'(bus.exit_gate_open), 0);
        step;
        chk("t4_timeout_one_cycle", 32'(bus.gate_timeout), 0);
        step(2);

        // 5: simultaneous passes at both gates
        bus.hour = 5'd9; bus.is_vacated_space = 1;
        bus.entry_is_uni = 0; bus.entry_req = 1;
        step;
        bus.entry_req = 0;
        bus.exit_is_uni = 1; bus.exit_req = 1;
        step;
        bus.exit_req = 0; bus.exit_is_uni = 0;
        chk("t5_both_open", 32'({bus.entry_gate_open, bus.exit_gate_open}), 2'b11);
        bus.entry_pass = 1; bus.exit_pass = 1;
        step;
        chk("t5_events", 32'({bus.car_entered, bus.is_uni_car_entered,
                              bus.car_exited, bus.is_uni_car_exited}), 4'b1011);
        chk("t5_both_closed", 32'({bus.entry_gate_open, bus.exit_gate_open}), 2'b00);
        bus.entry_pass = 0; bus.exit_pass = 0;
        step;
        chk("t5_events_cleared", 32'(outs()), 0);
        step(4);

        // 6: reset while the entry barrier is open
        bus.entry_is_uni = 0; bus.entry_req = 1;
        step;
        bus.entry_req = 0;
        step;
        chk("t6_open", 32'(bus.entry_gate_open), 1);
        #2 rst_n = 1'b0;
        #1 chk("t6_rst_immediate", 32'(outs()), 0);
        step;
        rst_n = 1'b1;
        bus.entry_pass = 1;
        step(2);
        chk("t6_no_event_after", 32'(outs()), 0);
        bus.entry_pass = 0;
        step(2);
        chk("t6_still_quiet", 32'(outs()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
